// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: FSM encoding, drain length and lane slicing.
`ifndef SA_PKG_SV
`define SA_PKG_SV

`define SA_LANE(idx, dw) ((idx)*(dw)) +: (dw)

package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sa_state_e;

  // Zero-fill length after the last beat: enough for the slowest lane to cross the whole grid.
  function automatic int drain_cycles(input int n);
    return 32'sd2 * n;
  endfunction

endpackage

`endif

// File: rtl/systolic_skew_feeder_skew_line.sv
// Fixed-depth shift register; one lane of the diagonal skew, shifting every cycle.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_push,
  output logic [DATA_WIDTH-1:0] o_tap
);

  logic [DATA_WIDTH-1:0] r_stage [DEPTH];

  // Shift chain: stage 0 takes the pushed value, the last stage drives the tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_stage[s] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_stage[0] <= i_push;
      for (int s = 1; s < DEPTH; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_tap = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Input-staging stage for an NxN MAC grid: job sequencing FSM, bubble insertion and per-lane skew.
module systolic_skew_feeder
  import sa_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  input  logic                    in_last,
  output logic [N*DATA_WIDTH-1:0] row_out,
  output logic [N*DATA_WIDTH-1:0] col_out,
  output logic                    array_clear,
  output logic                    busy,
  output logic                    done
);

  localparam int W     = N * DATA_WIDTH;
  localparam int DRAIN = drain_cycles(N);
  localparam int CW    = $clog2(DRAIN + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

  sa_state_e       r_state;
  sa_state_e       w_state_nxt;
  logic [CW-1:0]   r_drain_cnt;
  logic [CW-1:0]   w_drain_cnt_nxt;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_array_clear;
  logic            r_done;
  logic            w_xfer;
  logic [W-1:0]    w_push_a;
  logic [W-1:0]    w_push_b;

  // r_in_ready mirrors (state == FEED), so the handshake never depends combinationally on in_valid.
  assign w_xfer = r_in_ready & in_valid;

  // Next-state and drain counter.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: w_state_nxt = ST_FEED;
      ST_FEED: begin
        if (w_xfer && in_last) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = {CW{1'b0}};
        end else begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt     = ST_DONE;
          w_drain_cnt_nxt = {CW{1'b0}};
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt     = ST_IDLE;
        w_drain_cnt_nxt = {CW{1'b0}};
      end
    endcase
  end

  // Anything other than an accepted beat enters the skew lines as a zero bubble.
  always_comb begin
    if (w_xfer) begin
      w_push_a = in_a;
      w_push_b = in_b;
    end else begin
      w_push_a = {W{1'b0}};
      w_push_b = {W{1'b0}};
    end
  end

  // State register and flag outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= {CW{1'b0}};
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_array_clear <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_drain_cnt_nxt;
      r_in_ready    <= (w_state_nxt == ST_FEED);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_array_clear <= (w_state_nxt == ST_CLEAR);
      r_done        <= (w_state_nxt == ST_DONE);
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign array_clear = r_array_clear;
  assign done        = r_done;

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.DEPTH(g + 1), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push_a[`SA_LANE(g, DATA_WIDTH)]),
      .o_tap   (row_out[`SA_LANE(g, DATA_WIDTH)])
    );
    skew_line #(.DEPTH(g + 1), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push_b[`SA_LANE(g, DATA_WIDTH)]),
      .o_tap   (col_out[`SA_LANE(g, DATA_WIDTH)])
    );
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Input-staging stage placed directly upstream of the N×N MAC systolic grid. Accepts one operand vector pair per handshake (column k of A, row k of B), applies the diagonal skew the grid requires (lane i delayed i cycles), and drives the west-edge (A) and north-edge (B) operand inputs of the grid. It also sequences a job: clearing the grid accumulators before the first beat, zero-filling the pipeline after the last beat, and signalling when all grid results are final.

## Interface
- N, 4, array dimension (lanes per edge); N ≥ 2
- DATA_WIDTH, 8, operand width; matches the grid's DATA_WIDTH
- clk  in  1  single clock; all state on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an operand vector pair
- in_ready  out  1  feeder accepts a beat; a beat transfers when in_valid & in_ready
- in_a  in  N*DATA_WIDTH  column k of A; element i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_b  in  N*DATA_WIDTH  row k of B; element j in bits [j*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  qualifies the final beat (k = K-1) of a job
- row_out  out  N*DATA_WIDTH  skewed A lanes to grid west edge (lane i → grid row i)
- col_out  out  N*DATA_WIDTH  skewed B lanes to grid north edge (lane j → grid column j)
- array_clear  out  1  active-high, registered; ORed with system reset into the grid's reset
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse: all N×N grid results are final

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: in_ready=0. in_valid=1 → CLEAR next cycle (beat not consumed).
- CLEAR: exactly one cycle; array_clear=1, in_ready=0; → FEED.
- FEED: in_ready=1. Accepted beat pushes in_a/in_b lane-wise into skew lines; a cycle with no transfer pushes all-zero vectors (bubble) on every lane, preserving alignment because all lanes shift together. Transfer with in_last=1 → DRAIN. K=1 (in_last on first beat) is legal.
- DRAIN: in_ready=0; pushes zeros for exactly 2N cycles; → DONE.
- DONE: one cycle; done=1; → IDLE. in_valid in DONE is ignored; if still high in IDLE, next job starts normally.
- Skew line lane i: i+1 registers; lane output = value pushed i+1 cycles earlier. Identical for A and B lanes.
- No arithmetic; data passes unmodified. Zero bubbles contribute 0 to MAC accumulation.
- busy = (state ≠ IDLE); in_ready = (state == FEED), decoded from the state register only (no combinational path from in_valid).

## Timing
- Reset (asynchronous assert, deassert synchronized externally): state=IDLE; row_out, col_out, all skew registers = 0; array_clear=0, done=0, in_ready=0, busy=0.
- Reset mid-job: same values immediately; partially fed data discarded; next job must restart from beat 0.
- Job start: in_valid seen in IDLE at edge c0 → CLEAR during c1 (array_clear=1) → FEED from c2, first possible acceptance at edge ending c2.
- Beat accepted at edge t: lane i of row_out/col_out carries it during cycle t+1+i, zero (or neighbouring beats) otherwise.
- Last beat accepted at edge t: DRAIN occupies cycles t+1 … t+2N; done=1 during cycle t+2N+1.
- Outputs change on the rising edge and are stable at the grid's falling-edge sampling point (half-cycle margin).

## Structure
- Shared package/header sa_pkg: FSM state encoding, DRAIN_CYCLES = 2*N, lane slice helper macro for [i*DATA_WIDTH +: DATA_WIDTH].
- Sub-module skew_line (parameters DEPTH, DATA_WIDTH; shift-register, async active-low reset, push-every-cycle), instantiated 2N times with DEPTH=i+1.
- Top holds the FSM, drain counter (width $clog2(2N+1)), and bubble mux.

## Test plan
- Reset: hold reset_n=0 with random inputs → all outputs 0, in_ready=0; release → IDLE, busy=0.
- Single beat, N=4, in_a={4,3,2,1}, in_b={8,7,6,5} (lane 0 = 1/5): row_out lane i = i+1 and col_out lane j = j+5 exactly in cycle t+1+i / t+1+j, zero otherwise; array_clear one cycle; done at t+9.
- Integration with 4×4 MAC grid: A=identity, B=1..16 row-major, K=4 contiguous → grid results equal B; done asserted only after final accumulation.
- Bubbles: same job with in_valid low for 3 cycles between beats 1 and 2 → zero vectors on outputs during gaps; grid results identical to contiguous run.
- Reset mid-FEED after beat 2 → outputs zero immediately; rerun full job → correct results.
- Back-to-back jobs, in_valid held high through DONE: job 2 = A all 1s, B all 2s, K=4 → array_clear precedes job 2, every result = 8 with no residue from job 1.
